// File: rtl/gcd_arb_pkg.sv
// Shared types and constants for the two-requester GCD arbiter.
package gcd_arb_pkg;

  // Default operand / result width.
  localparam int DATA_BITS_DEFAULT = 4;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Identifies which requester owns a job (0 or 1).
  typedef logic req_id_t;

  // Value of the round-robin history after reset, so requester 0 wins the first tie.
  localparam req_id_t LAST_GRANT_RESET = 1'b1;

endpackage

// File: rtl/gcd_engine.sv
// Iterative subtract-based GCD engine: holds the two working operands and
// performs one "replace larger by larger-smaller" step per enabled cycle.
module gcd_engine
  import gcd_arb_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] x,
  input  logic [DATA_BITS-1:0] y,
  input  logic                 step,
  output logic                 done,
  output logic [DATA_BITS-1:0] result
);

  logic [DATA_BITS-1:0] a;
  logic [DATA_BITS-1:0] b;

  // Termination test and result selection; a zero operand yields the other one,
  // which also makes gcd(0,0)=0.
  always_comb begin
    done   = (a == '0) || (b == '0) || (a == b);
    result = (a == '0) ? b : a;
  end

  // Operand registers: load a new pair, or subtract smaller from larger so the
  // unsigned difference can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
    end else if (load) begin
      a <= x;
      b <= y;
    end else if (step && !done) begin
      if (a > b) begin
        a <= a - b;
      end else begin
        b <= b - a;
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Two-requester arbiter and sequencer around one shared gcd_engine.
// Optional feature macro: GCD_ARB_ROUND_ROBIN_EN selects round-robin tie
// breaking; when undefined, requester 0 has fixed priority.
module gcd_arbiter
  import gcd_arb_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req0_valid_i,
  input  logic [DATA_BITS-1:0] req0_x_i,
  input  logic [DATA_BITS-1:0] req0_y_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [DATA_BITS-1:0] req1_x_i,
  input  logic [DATA_BITS-1:0] req1_y_i,
  output logic                 req1_ready_o,
  output logic                 rsp_valid_o,
  output logic                 rsp_id_o,
  output logic [DATA_BITS-1:0] rsp_result_o,
  output logic                 busy_o
);

  state_t               state;
  state_t               state_next;
  logic [1:0]           grant;
  logic                 xfer0;
  logic                 xfer1;
  logic                 xfer;
  logic                 step;
  logic [DATA_BITS-1:0] load_x;
  logic [DATA_BITS-1:0] load_y;
  logic                 eng_done;
  logic [DATA_BITS-1:0] eng_result;
  req_id_t              job_id;
  req_id_t              rsp_id;
  logic [DATA_BITS-1:0] rsp_result;

`ifdef GCD_ARB_ROUND_ROBIN_EN
  req_id_t last_grant;

  // Round-robin grant: on a tie favour the requester not served last.
  always_comb begin
    grant = {req1_valid_i, req0_valid_i};
    if (req0_valid_i && req1_valid_i) begin
      grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
    end
  end

  // Remember who won the most recent transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant <= LAST_GRANT_RESET;
    end else if (xfer) begin
      last_grant <= xfer1;
    end
  end
`else
  // Fixed priority grant: requester 0 always wins a tie.
  always_comb begin
    grant = {req1_valid_i & ~req0_valid_i, req0_valid_i};
  end
`endif

  // Ready only while idle and out of reset, so ready is low throughout reset.
  assign req0_ready_o = rst_ni & (state == IDLE) & grant[0];
  assign req1_ready_o = rst_ni & (state == IDLE) & grant[1];

  assign xfer0 = req0_valid_i & req0_ready_o;
  assign xfer1 = req1_valid_i & req1_ready_o;
  assign xfer  = xfer0 | xfer1;

  // Operand mux: at most one transfer per cycle, so select by requester 1's transfer.
  always_comb begin
    load_x = xfer1 ? req1_x_i : req0_x_i;
    load_y = xfer1 ? req1_y_i : req0_y_i;
  end

  gcd_engine #(
    .DATA_BITS (DATA_BITS)
  ) u_engine (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .load   (xfer),
    .x      (load_x),
    .y      (load_y),
    .step   (step),
    .done   (eng_done),
    .result (eng_result)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and engine step enable.
  always_comb begin
    state_next = state;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (eng_done) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Tag the accepted job with its requester.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      job_id <= 1'b0;
    end else if (xfer) begin
      job_id <= xfer1;
    end
  end

  // Capture the result as RUN finishes so it is visible during RESP and held after.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_result <= '0;
      rsp_id     <= 1'b0;
    end else if ((state == RUN) && eng_done) begin
      rsp_result <= eng_result;
      rsp_id     <= job_id;
    end
  end

  assign rsp_valid_o  = (state == RESP);
  assign rsp_id_o     = rsp_id;
  assign rsp_result_o = rsp_result;
  assign busy_o       = (state != IDLE);

endmodule

// File: doc/gcd_arbiter.md
# gcd_arbiter

Two-requester arbiter and sequencer for a shared iterative subtract-based GCD engine. Each requester presents an operand pair with a valid/ready handshake. The arbiter grants one requester, runs the engine to completion and returns a tagged result. It sits between operand-entry front ends (keypad/switch FSMs) and the seven-segment result decoder, so that one engine serves both front ends.

## Interface
- DATA_BITS, 4, operand and result width
- clk_i  in  1  rising-edge clock
- rst_ni  in  1  asynchronous, active-low reset
- req0_valid_i  in  1  requester 0 holds an operand pair
- req0_x_i, req0_y_i  in  DATA_BITS each  requester 0 operands
- req0_ready_o  out  1  requester 0 accepted this cycle
- req1_valid_i, req1_x_i, req1_y_i, req1_ready_o  same as requester 0, for requester 1
- rsp_valid_o  out  1  one-cycle pulse, result available
- rsp_id_o  out  1  requester served (0/1)
- rsp_result_o  out  DATA_BITS  GCD, held until the next response
- busy_o  out  1  a job is accepted and not yet responded

## Operation
- FSM states: IDLE, RUN, RESP.
- IDLE: the combinational grant picks a winner among the valid requesters. reqN_ready_o = (state==IDLE) & grant[N]. A transfer occurs when valid & ready. On transfer: latch x and y into the engine, latch the id, and go to RUN.
- RUN: evaluated once per cycle on engine registers a and b.
  - If a==0: result=b, go to RESP.
  - Else if b==0: result=a, go to RESP.
  - Else if a==b: result=a, go to RESP.
  - Else replace the larger operand with larger−smaller and stay in RUN.
- Subtraction is unsigned DATA_BITS wide and never underflows, because the smaller operand is always subtracted from the larger.
- gcd(0,0)=0.
- RESP: rsp_valid_o=1 for one cycle, rsp_id_o and rsp_result_o update, then go to IDLE.
- busy_o = (state != IDLE).
- Requester rules:
  - Operands must be stable while valid is high; this is not checked.
  - Deasserting valid before ready is allowed and has no effect.
  - valid arriving during RUN or RESP waits; ready stays low.
- Reset values: state=IDLE, all ready=0, rsp_valid_o=0, rsp_id_o=0, rsp_result_o=0, busy_o=0, engine registers=0, last-grant register=1.
- Asynchronous reset during RUN or RESP drops the job silently; no response is ever produced for it.

## Timing
- Let S be the number of subtraction steps and c the transfer cycle. rsp_valid_o is high in cycle c+S+2.
  - S=0 for zero or equal operands.
  - gcd(12,8): S=2, response in c+4.
  - gcd(15,1): S=14, response in c+16 (worst case for DATA_BITS=4).
- The earliest next transfer is c+S+3, the first IDLE cycle after RESP.
- busy_o rises in c+1 and falls in c+S+3.
- Grant is decided in the same cycle as ready, with no extra arbitration cycle.

## Configuration
- GCD_ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
  - When both requesters are valid, grant the one not granted last (last-grant register resets to 1, so requester 0 wins the first tie).
  - The last-grant register updates on each transfer.
- Undefined: fixed priority; requester 0 always wins ties.
  - The last-grant register is absent.
  - Requester 1 can starve if requester 0 stays valid.
- A single requester that is valid alone is granted in both modes.

## Structure
- Package gcd_arb_pkg:
  - FSM state enum (IDLE/RUN/RESP)
  - requester-id type
  - default DATA_BITS constant
- Sub-module gcd_engine:
  - holds a and b plus the RUN-step logic
  - ports: load, x, y, step enable, done, result
  - the arbiter instantiates one instance and owns the FSM and arbitration.

## Test plan
- Reset: assert rst_ni low mid-clock. All outputs go 0 immediately (asynchronously), and busy_o stays 0 after release with no requests.
- Requester 0 only, (12,8): transfer at c, then rsp_valid_o pulses at c+4 with id=0 and result=4. busy_o is high over c+1..c+4.
- Zero and equal operands: (0,5) gives 5 at c+2; (0,0) gives 0 at c+2; (7,7) gives 7 at c+2.
- Worst case (15,1): response 1 at c+16. req1_valid_i asserted during RUN sees ready=0 until IDLE, then transfers at c+17.
- Both requesters valid continuously with (6,4) and (9,3):
  - With GCD_ARB_ROUND_ROBIN_EN: responses alternate id 0,1,0 with results 2,3,2.
  - Without it: every response is id 0 with result 2.
- Reset mid-RUN on (15,1) at c+5: no response is emitted. After release, request (8,4) completes normally with 4 at its own c+3.
